// File: rtl/pc_pkg.sv
// pc_pkg: shared definitions for the fetch path.
//   fetch_state_e    : fetch FSM states (BOOT, REQ, WAIT, HOLD, FAULT)
//   PC_STEP          : sequential PC increment in bytes
//   DEFAULT_RESET_PC : PC loaded on reset unless overridden
package pc_pkg;

  typedef enum logic [2:0] {
    ST_BOOT  = 3'd0,
    ST_REQ   = 3'd1,
    ST_WAIT  = 3'd2,
    ST_HOLD  = 3'd3,
    ST_FAULT = 3'd4
  } fetch_state_e;

  localparam int unsigned PC_STEP          = 32'd4;
  localparam logic [31:0] DEFAULT_RESET_PC = 32'h0000_0000;

endpackage

// File: rtl/pc_fetch_buf.sv
// pc_fetch_buf: one-entry instruction buffer between the fetch FSM and decode.
// Ports:
//   clk, reset_n        : clock, asynchronous active-low reset
//   load                : capture load_data/load_pc and present them to decode
//   drop                : discard the buffered instruction (redirect)
//   consume             : decode took the instruction
//   load_data, load_pc  : instruction word and its PC
//   inst_valid          : buffered instruction available
//   inst_data, inst_pc  : buffered instruction and its PC; held while valid
module pc_fetch_buf
  import pc_pkg::*;
#(
  parameter int unsigned ADDR_W = 32
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              load,
  input  logic              drop,
  input  logic              consume,
  input  logic [31:0]       load_data,
  input  logic [ADDR_W-1:0] load_pc,
  output logic              inst_valid,
  output logic [31:0]       inst_data,
  output logic [ADDR_W-1:0] inst_pc
);

  // Buffer register: load wins; drop/consume only clear valid so data stays stable
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      inst_valid <= 1'b0;
      inst_data  <= 32'h0000_0000;
      inst_pc    <= '0;
    end else if (load) begin
      inst_valid <= 1'b1;
      inst_data  <= load_data;
      inst_pc    <= load_pc;
    end else if (drop || consume) begin
      inst_valid <= 1'b0;
    end
  end

endmodule

// File: rtl/pc_fetch_unit.sv
// pc_fetch_unit: owns the architectural PC, issues one fetch at a time to
// instruction memory and hands the returned word to decode.
// Ports:
//   clk, reset_n                   : clock, asynchronous active-low reset
//   imem_req_valid/ready, imem_addr: fetch request handshake, word-aligned address
//   imem_rsp_valid, imem_rsp_data  : single-cycle response per accepted request
//   inst_valid/ready, inst_data,
//   inst_pc                        : instruction handoff to decode
//   redirect_valid, redirect_target: taken branch/jump
//   fetch_fault                    : sticky misaligned-redirect trap
//                                    (only when PC_MISALIGN_TRAP_EN is defined)
// Configuration macro: PC_MISALIGN_TRAP_EN. Without it, the low two target
// bits are cleared silently.
module pc_fetch_unit
  import pc_pkg::*;
#(
  parameter int unsigned       ADDR_W   = 32,
  parameter logic [ADDR_W-1:0] RESET_PC = ADDR_W'(DEFAULT_RESET_PC)
) (
  input  logic              clk,
  input  logic              reset_n,
  output logic              imem_req_valid,
  input  logic              imem_req_ready,
  output logic [ADDR_W-1:0] imem_addr,
  input  logic              imem_rsp_valid,
  input  logic [31:0]       imem_rsp_data,
  output logic              inst_valid,
  input  logic              inst_ready,
  output logic [31:0]       inst_data,
  output logic [ADDR_W-1:0] inst_pc,
`ifdef PC_MISALIGN_TRAP_EN
  output logic              fetch_fault,
`endif
  input  logic              redirect_valid,
  input  logic [ADDR_W-1:0] redirect_target
);

  fetch_state_e      state_r;
  logic [ADDR_W-1:0] pc_r;
  logic [ADDR_W-1:0] addr_r;
  logic              squash_r;
  logic              req_valid_r;

  logic [ADDR_W-1:0] tgt_al_s;
  logic [ADDR_W-1:0] pc_inc_s;
  logic              redir_ok_s;
  logic              buf_load_s;
  logic              buf_drop_s;
  logic              buf_consume_s;

`ifdef PC_MISALIGN_TRAP_EN
  logic              fault_r;
  logic              redir_trap_s;
`endif

  // Target alignment, sequential increment and buffer controls
  always_comb begin
    tgt_al_s = redirect_target & ~ADDR_W'(2'd3);
    pc_inc_s = pc_r + ADDR_W'(PC_STEP);
`ifdef PC_MISALIGN_TRAP_EN
    redir_trap_s = redirect_valid && (redirect_target[1:0] != 2'b00);
    redir_ok_s   = redirect_valid && !redir_trap_s;
`else
    redir_ok_s   = redirect_valid;
`endif
    // Any redirect (even one that traps) makes the returning word stale
    buf_load_s    = (state_r == ST_WAIT) && imem_rsp_valid && !squash_r && !redirect_valid;
    buf_drop_s    = (state_r == ST_HOLD) && redirect_valid;
    buf_consume_s = (state_r == ST_HOLD) && inst_ready && !redirect_valid;
  end

  // Fetch FSM: owns pc, the request address, the squash flag and req_valid
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_r     <= ST_BOOT;
      pc_r        <= RESET_PC;
      addr_r      <= RESET_PC;
      squash_r    <= 1'b0;
      req_valid_r <= 1'b0;
`ifdef PC_MISALIGN_TRAP_EN
      fault_r     <= 1'b0;
`endif
    end else begin
      case (state_r)
        ST_BOOT: begin
          // Redirects are ignored here
          addr_r      <= pc_r;
          req_valid_r <= 1'b1;
          state_r     <= ST_REQ;
        end
        ST_REQ: begin
          // The pending request is never changed; a redirect only marks it stale
          if (imem_req_ready) begin
            req_valid_r <= 1'b0;
            state_r     <= ST_WAIT;
          end
          if (redir_ok_s) begin
            pc_r     <= tgt_al_s;
            squash_r <= 1'b1;
          end
        end
        ST_WAIT: begin
          if (imem_rsp_valid) begin
            if (redir_ok_s) begin
              // Response is stale and the new target is known: fetch it directly
              pc_r        <= tgt_al_s;
              addr_r      <= tgt_al_s;
              squash_r    <= 1'b0;
              req_valid_r <= 1'b1;
              state_r     <= ST_REQ;
            end else if (squash_r) begin
              addr_r      <= pc_r;
              squash_r    <= 1'b0;
              req_valid_r <= 1'b1;
              state_r     <= ST_REQ;
            end else begin
              state_r     <= ST_HOLD;
            end
          end else if (redir_ok_s) begin
            pc_r     <= tgt_al_s;
            squash_r <= 1'b1;
          end
        end
        ST_HOLD: begin
          // Redirect has priority over a simultaneous consume
          if (redir_ok_s) begin
            pc_r        <= tgt_al_s;
            addr_r      <= tgt_al_s;
            req_valid_r <= 1'b1;
            state_r     <= ST_REQ;
          end else if (inst_ready) begin
            pc_r        <= pc_inc_s;
            addr_r      <= pc_inc_s;
            req_valid_r <= 1'b1;
            state_r     <= ST_REQ;
          end
        end
        ST_FAULT: begin
          state_r     <= ST_FAULT;
          req_valid_r <= 1'b0;
        end
        default: begin
          state_r     <= ST_BOOT;
          req_valid_r <= 1'b0;
        end
      endcase
`ifdef PC_MISALIGN_TRAP_EN
      // Misaligned redirect overrides everything above; pc keeps its value
      if (redir_trap_s && (state_r != ST_BOOT)) begin
        state_r     <= ST_FAULT;
        req_valid_r <= 1'b0;
        fault_r     <= 1'b1;
      end
`endif
    end
  end

  assign imem_req_valid = req_valid_r;
  assign imem_addr      = addr_r;
`ifdef PC_MISALIGN_TRAP_EN
  assign fetch_fault    = fault_r;
`endif

  pc_fetch_buf #(
    .ADDR_W (ADDR_W)
  ) u_buf (
    .clk        (clk),
    .reset_n    (reset_n),
    .load       (buf_load_s),
    .drop       (buf_drop_s),
    .consume    (buf_consume_s),
    .load_data  (imem_rsp_data),
    .load_pc    (addr_r),
    .inst_valid (inst_valid),
    .inst_data  (inst_data),
    .inst_pc    (inst_pc)
  );

endmodule
